// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, ROM addressing, IF/ID register
module fetch_stage #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state: halt beats redirect, redirect beats stall, otherwise advance and load IF/ID.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        fetch_count_d = fetch_count_q;

        if (state_q == HALTED || halt) begin
            // Frozen: PC holds and IF/ID drains to a bubble.
            state_d    = HALTED;
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
        end else if (redirect) begin
            // The instruction sitting in IF/ID is on the wrong path, even if decode is stalled.
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
        end else if (!stall) begin
            pc_d       = pc_plus4;
            id_valid_d = 1'b1;
            id_instr_d = rom_data;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            if (fetch_count_q != 32'hFFFF_FFFF) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC_ALIGNED;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_q       <= 32'h0;
            id_pc4_q      <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rom_addr    = pc_q[ADDR_W+1:2];
    assign pc          = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc4      = id_pc4_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU: owns the PC register, drives the instruction ROM address and captures the returned word into the IF/ID pipeline register.
- Its id_instr output feeds the decode stage, including the immediate/shift-amount extender.
- Handles load-use stalls, branch/jump redirects with a bubble, and the sticky halt raised by a halting syscall.

Parameters:
- ADDR_W, 10, ROM word-address width (ROM depth = 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are treated as 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  load-use hazard from decode: hold the PC and IF/ID.
- redirect  input  1  taken branch or jump resolved downstream: load redirect_pc and flush IF/ID.
- redirect_pc  input  32  target PC; bits [1:0] are ignored and forced to 0.
- halt  input  1  halting syscall reached; freezes fetch until reset.
- rom_addr  output  ADDR_W  ROM word address, equal to pc[ADDR_W+1:2], combinational.
- rom_data  input  32  ROM read data, combinational (asynchronous read) for rom_addr.
- pc  output  32  current fetch PC (registered).
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  IF/ID instruction word; 32'h0 (NOP) when not valid.
- id_pc  output  32  PC of id_instr.
- id_pc4  output  32  id_pc + 4.
- halted  output  1  sticky halt flag.
- fetch_count  output  32  number of valid instructions loaded into IF/ID; saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc = RESET_PC.
  - id_valid = 0; id_instr, id_pc, id_pc4 = 0.
  - halted = 0; fetch_count = 0.
  - rst overrides every other input.
- Fetch state: RUN (halted=0) or HALTED (halted=1).
  - RUN→HALTED on a clk edge with halt=1.
  - HALTED is left only by rst.
- PC next-state priority, highest first:
  1. rst
  2. halted=1 or halt=1: hold
  3. redirect: pc = {redirect_pc[31:2],2'b00}
  4. stall: hold
  5. else pc = pc+4, wrapping modulo 2^32
- IF/ID next-state priority, highest first:
  1. rst
  2. halted=1, halt=1 or redirect=1: bubble (id_valid=0, id_instr/id_pc/id_pc4 = 0)
  3. stall: hold all IF/ID fields unchanged
  4. else load id_instr=rom_data, id_pc=pc, id_pc4=pc+4, id_valid=1
- redirect together with stall: redirect wins. The PC takes the target and IF/ID becomes a bubble, because the stalled decode instruction is on the wrong path.
- halt together with redirect: halt wins. The PC holds, IF/ID becomes a bubble, and halted becomes 1.
- Latency:
  - Instruction at PC P appears on id_instr one clk edge after pc==P, provided no stall or redirect occurs in that cycle.
  - A redirect asserted in cycle N gives pc = target after edge N and the target instruction in IF/ID after edge N+1. Exactly one bubble cycle results.
- ROM wrap: rom_addr truncates the PC, so fetch past the last ROM word wraps to word 0. pc itself keeps counting in 32 bits.
- fetch_count:
  - +1 on every edge that performs an IF/ID load with id_valid=1.
  - Holds at 32'hFFFF_FFFF (no wrap).
  - No change on stall, bubble or halt.
- All outputs except rom_addr are registered; there is no combinational path from inputs to outputs other than pc→rom_addr.

Test Plan:
- Reset then free-run with ROM word k = 32'h1000_0000+k, no stall, ADDR_W=10 → after 3 edges: pc=0x0C, id_instr=0x1000_0002, id_pc=0x08, id_pc4=0x0C, id_valid=1, fetch_count=3.
- Assert stall for 2 cycles with pc=0x10 → pc stays 0x10 and IF/ID holds id_pc=0x0C for both edges, fetch_count unchanged. After release, id_pc=0x10 on the next edge.
- redirect=1 with redirect_pc=0x0000_0103 at pc=0x20 → next edge: pc=0x100, id_valid=0, id_instr=0. Following edge: id_pc=0x100, id_instr=0x1000_0040.
- stall=1 and redirect=1 in the same cycle (target 0x40) → pc=0x40, IF/ID bubble. Stall is ignored.
- halt=1 for one cycle at pc=0x30 → halted=1, IF/ID bubble, pc frozen at 0x30 and fetch_count frozen for 10+ cycles despite stall/redirect activity. rst=1 then returns pc=RESET_PC and halted=0.
- Start at pc=0xFFC (redirect) with ADDR_W=10 → rom_addr=1023, then next edge pc=0x1000, rom_addr=0, id_instr=0x1000_03FF, with ROM wrap verified.
